rmii_rx_to_mii: RTL and testbench
=================================

RMII_RX_TO_MII -- requirements
Module: rmii_rx_to_mii

Interface
REQ-001 Parameter SPEED_DIV_10, default 10, sys_clk cycles per dibit sample in 10 Mb/s mode.
REQ-002 sys_clk  input  1  50 MHz RMII reference clock; all logic on rising edge.
REQ-003 resetn  input  1  reset, synchronous and active-low.
REQ-004 speed_100  input  1  1 = 100 Mb/s (sample every cycle), 0 = 10 Mb/s (sample every SPEED_DIV_10 cycles).
REQ-005 phy2rmii_crs_dv  input  1  RMII carrier-sense / data-valid.
REQ-006 phy2rmii_rx_er  input  1  RMII receive error.
REQ-007 phy2rmii_rxd  input  2  RMII receive dibit, LSB-first.
REQ-008 mii_rxd  output  4  assembled nibble, first dibit in [1:0].
REQ-009 mii_rx_en  output  1  one-cycle strobe, mii_rxd/mii_rx_dv/mii_rx_er valid.
REQ-010 mii_rx_dv  output  1  frame data valid, held from first emitted nibble to end of frame.
REQ-011 mii_rx_er  output  1  error flag for the strobed nibble.
REQ-012 mii_crs  output  1  registered carrier indication.

Function
REQ-013 Sample strobe: every cycle when speed_100=1; when 0, a 0..SPEED_DIV_10-1 counter strobes at 0 and restarts at 0 on the crs_dv rising edge in IDLE.
REQ-014 States IDLE, PREAMBLE, DATA; state logic advances only on sample strobes.
REQ-015 IDLE: crs_dv=1 and rxd=01 -> PREAMBLE; crs_dv=1 with rxd=00 or 10 (false carrier) stays IDLE, no output.
REQ-016 PREAMBLE: every second consecutive 01 dibit emits nibble 0x5 with mii_rx_dv=1.
REQ-017 PREAMBLE: 11 following 01 emits 0xD (SFD), clears nibble phase to 0, -> DATA.
REQ-018 PREAMBLE: 00 or 10 with crs_dv=1 -> IDLE, mii_rx_dv deasserted, no further nibble.
REQ-019 DATA: dibits pair in order (phase 0 then 1); each completed pair emits one nibble.
REQ-020 DATA: crs_dv=0 on one sample with crs_dv=1 on the next is RMII carrier-loss toggling; both dibits remain data.
REQ-021 DATA: crs_dv=0 on two consecutive samples ends the frame; any half-nibble is discarded, mii_rx_dv=0 on the following cycle, -> IDLE.
REQ-022 mii_rx_er=1 on an emitted nibble if rx_er was high on either of its dibits.
REQ-023 Latency: mii_rx_en pulses exactly 1 sys_clk cycle after the sample completing the nibble.
REQ-024 mii_rx_en is never high on two consecutive cycles; it pulses only when mii_rx_dv=1.
REQ-025 mii_crs follows crs_dv registered once, sampled every cycle regardless of strobe.
REQ-026 A speed_100 change is honoured only in IDLE; mid-frame it is ignored until IDLE.
REQ-027 Counter wrap: the 10 Mb/s counter wraps SPEED_DIV_10-1 -> 0 with no skipped or doubled strobe.

Reset
REQ-028 resetn=0 at any rising edge: state IDLE, phase 0, counter 0, mii_rxd=0, mii_rx_en=0, mii_rx_dv=0, mii_rx_er=0, mii_crs=0.
REQ-029 Reset mid-frame aborts with no further strobe; after release the next frame requires a fresh preamble.

Structure
REQ-030 Shared package rmii_pkg holds the state enum, dibit constants (PRE=01, SFD=11) and the default divider value.
REQ-031 Sample strobe generator is sub-module rmii_sample_strobe (counter plus speed select); the rest stays in one module.

Verification
REQ-032 100M: crs_dv=1 with 7x(01,01) then (01,11) then byte 0xA5 -> nibbles 5x7, D, 5, A, one cycle apart per pair, rx_dv continuous.
REQ-033 100M end of frame: data, then crs_dv 0,1,0,1 toggles, then 0,0 -> toggled dibits delivered, rx_dv falls one cycle after the second 0, partial nibble dropped.
REQ-034 10M: the REQ-032 stream with each dibit held 10 cycles -> identical nibble sequence, rx_en spacing 20 cycles.
REQ-035 rx_er high on one dibit of data byte 0x3C -> only that nibble has mii_rx_er=1.
REQ-036 False carrier rxd=10, then resetn=0 mid-DATA -> no output; all outputs 0 one cycle after reset; the next valid frame is received correctly.

Source files
------------

// File: rtl/rmii_pkg.sv
// Shared types and constants for the RMII receive-to-MII converter.
package rmii_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StData
  } rx_state_e;

  localparam logic [1:0] DibitPre = 2'b01;
  localparam logic [1:0] DibitSfd = 2'b11;

  localparam int unsigned SpeedDiv10Default = 10;

  // RMII sends LSB-first, so the first dibit lands in the low half of the nibble.
  function automatic logic [3:0] pack_nibble(input logic [1:0] first, input logic [1:0] second);
    return {second, first};
  endfunction

endpackage

// File: rtl/rmii_rx_to_mii_if.sv
// PHY-side RMII receive signals and MII-side nibble outputs.
interface rmii_rx_to_mii_if;
  logic       speed_100;
  logic       phy2rmii_crs_dv;
  logic       phy2rmii_rx_er;
  logic [1:0] phy2rmii_rxd;
  logic [3:0] mii_rxd;
  logic       mii_rx_en;
  logic       mii_rx_dv;
  logic       mii_rx_er;
  logic       mii_crs;

  modport master (
    output speed_100, phy2rmii_crs_dv, phy2rmii_rx_er, phy2rmii_rxd,
    input  mii_rxd, mii_rx_en, mii_rx_dv, mii_rx_er, mii_crs
  );

  modport slave (
    input  speed_100, phy2rmii_crs_dv, phy2rmii_rx_er, phy2rmii_rxd,
    output mii_rxd, mii_rx_en, mii_rx_dv, mii_rx_er, mii_crs
  );
endinterface

// File: rtl/rmii_sample_strobe.sv
// Dibit sample strobe: every cycle at 100 Mb/s, one in Div cycles at 10 Mb/s.
module rmii_sample_strobe
  import rmii_pkg::*;
#(
  parameter int unsigned Div = SpeedDiv10Default
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic speed_100_i,
  input  logic restart_i,
  output logic strobe_o
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    strobe_o = 1'b0;
    cnt_d    = cnt_q;
    if (speed_100_i) begin
      strobe_o = 1'b1;
      cnt_d    = '0;
    end else if (restart_i) begin
      // The restart cycle itself is count 0, so it strobes and moves on to 1.
      strobe_o = 1'b1;
      cnt_d    = (Div > 1) ? CntW'(1) : '0;
    end else begin
      strobe_o = (cnt_q == '0);
      cnt_d    = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rmii_rx_to_mii.sv
// RMII receive path: dibits to MII nibbles with preamble/SFD tracking and CRS_DV decoding.
module rmii_rx_to_mii
  import rmii_pkg::*;
#(
  parameter int unsigned SPEED_DIV_10 = SpeedDiv10Default
) (
  input logic               sys_clk,
  input logic               resetn,
  rmii_rx_to_mii_if.slave   bus
);

  rx_state_e  state_q, state_d;
  logic       phase_q, phase_d;
  logic [1:0] lo_q, lo_d;
  logic       lo_er_q, lo_er_d;
  logic       pend_q, pend_d;
  logic [1:0] pend_dibit_q, pend_dibit_d;
  logic       pend_er_q, pend_er_d;
  logic       spd_q, spd_d;
  logic [3:0] rxd_q, rxd_d;
  logic       en_q, en_d;
  logic       dv_q, dv_d;
  logic       er_q, er_d;
  logic       crs_q;

  logic       crs_dv, rx_er;
  logic [1:0] rxd;
  logic       speed_eff, restart, strobe;

  assign crs_dv = bus.phy2rmii_crs_dv;
  assign rx_er  = bus.phy2rmii_rx_er;
  assign rxd    = bus.phy2rmii_rxd;

  // Speed is tracked live while idle and frozen for the duration of a frame.
  assign speed_eff = (state_q == StIdle) ? bus.speed_100 : spd_q;
  assign spd_d     = speed_eff;
  assign restart   = (state_q == StIdle) && crs_dv && !crs_q;

  rmii_sample_strobe #(
    .Div (SPEED_DIV_10)
  ) u_strobe (
    .clk_i       (sys_clk),
    .rst_ni      (resetn),
    .speed_100_i (speed_eff),
    .restart_i   (restart),
    .strobe_o    (strobe)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    lo_d         = lo_q;
    lo_er_d      = lo_er_q;
    pend_d       = pend_q;
    pend_dibit_d = pend_dibit_q;
    pend_er_d    = pend_er_q;
    rxd_d        = rxd_q;
    en_d         = 1'b0;
    dv_d         = dv_q;
    er_d         = er_q;
    if (strobe) begin
      unique case (state_q)
        StIdle: begin
          dv_d = 1'b0;
          if (crs_dv && (rxd == DibitPre)) begin
            state_d = StPreamble;
            phase_d = 1'b1;
            lo_er_d = rx_er;
          end
        end
        StPreamble: begin
          if (crs_dv && (rxd == DibitPre)) begin
            phase_d = ~phase_q;
            lo_er_d = rx_er;
            if (phase_q) begin
              en_d  = 1'b1;
              dv_d  = 1'b1;
              rxd_d = pack_nibble(DibitPre, DibitPre);
              er_d  = lo_er_q | rx_er;
            end
          end else if (crs_dv && (rxd == DibitSfd)) begin
            en_d    = 1'b1;
            dv_d    = 1'b1;
            rxd_d   = pack_nibble(DibitPre, DibitSfd);
            er_d    = lo_er_q | rx_er;
            phase_d = 1'b0;
            pend_d  = 1'b0;
            state_d = StData;
          end else begin
            state_d = StIdle;
            dv_d    = 1'b0;
            phase_d = 1'b0;
          end
        end
        StData: begin
          // A low CRS_DV sample is held back until the next sample shows whether
          // it was carrier-loss toggling (data) or the end of the frame.
          if (!crs_dv) begin
            if (pend_q) begin
              state_d = StIdle;
              dv_d    = 1'b0;
              phase_d = 1'b0;
              pend_d  = 1'b0;
            end else begin
              pend_d       = 1'b1;
              pend_dibit_d = rxd;
              pend_er_d    = rx_er;
            end
          end else if (pend_q) begin
            pend_d = 1'b0;
            en_d   = 1'b1;
            dv_d   = 1'b1;
            if (!phase_q) begin
              rxd_d = pack_nibble(pend_dibit_q, rxd);
              er_d  = pend_er_q | rx_er;
            end else begin
              rxd_d   = pack_nibble(lo_q, pend_dibit_q);
              er_d    = lo_er_q | pend_er_q;
              lo_d    = rxd;
              lo_er_d = rx_er;
            end
          end else if (!phase_q) begin
            lo_d    = rxd;
            lo_er_d = rx_er;
            phase_d = 1'b1;
          end else begin
            en_d    = 1'b1;
            dv_d    = 1'b1;
            rxd_d   = pack_nibble(lo_q, rxd);
            er_d    = lo_er_q | rx_er;
            phase_d = 1'b0;
          end
        end
        default: begin
          state_d = StIdle;
          dv_d    = 1'b0;
          phase_d = 1'b0;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      phase_q      <= 1'b0;
      lo_q         <= 2'b00;
      lo_er_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_dibit_q <= 2'b00;
      pend_er_q    <= 1'b0;
      spd_q        <= 1'b0;
      rxd_q        <= 4'h0;
      en_q         <= 1'b0;
      dv_q         <= 1'b0;
      er_q         <= 1'b0;
      crs_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      lo_q         <= lo_d;
      lo_er_q      <= lo_er_d;
      pend_q       <= pend_d;
      pend_dibit_q <= pend_dibit_d;
      pend_er_q    <= pend_er_d;
      spd_q        <= spd_d;
      rxd_q        <= rxd_d;
      en_q         <= en_d;
      dv_q         <= dv_d;
      er_q         <= er_d;
      crs_q        <= crs_dv;
    end
  end

  assign bus.mii_rxd   = rxd_q;
  assign bus.mii_rx_en = en_q;
  assign bus.mii_rx_dv = dv_q;
  assign bus.mii_rx_er = er_q;
  assign bus.mii_crs   = crs_q;

endmodule

// File: tb/tb_rmii_rx_to_mii.sv
// Directed bench for rmii_rx_to_mii: 100M/10M frames, toggling CRS_DV, errors, false carrier, reset.
module tb_rmii_rx_to_mii;

  logic sys_clk = 1'b0;
  logic resetn  = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;

  always #10 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  rmii_rx_to_mii_if bus ();

  rmii_rx_to_mii #(
    .SPEED_DIV_10 (10)
  ) dut (
    .sys_clk (sys_clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  // Nibble monitor, sampled on the falling edge.
  logic [3:0] nib_q[$];
  logic       ner_q[$];
  int         t_q[$];
  int         consec_viol = 0;
  int         nodv_viol = 0;
  int         dv_falls = 0;
  logic       prev_en = 1'b0;
  logic       prev_dv = 1'b0;

  always @(negedge sys_clk) begin
    if (bus.mii_rx_en === 1'b1) begin
      nib_q.push_back(bus.mii_rxd);
      ner_q.push_back(bus.mii_rx_er);
      t_q.push_back(cyc);
      if (prev_en) consec_viol <= consec_viol + 1;
      if (bus.mii_rx_dv !== 1'b1) nodv_viol <= nodv_viol + 1;
    end
    if (prev_dv && (bus.mii_rx_dv !== 1'b1)) dv_falls <= dv_falls + 1;
    prev_en <= (bus.mii_rx_en === 1'b1);
    prev_dv <= (bus.mii_rx_dv === 1'b1);
  end

  logic [3:0] exp_std[10] = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'hD, 4'h5, 4'hA};
  logic [3:0] exp_tog[12] = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'hD, 4'h5, 4'hA,
                              4'hC, 4'h3};
  logic [3:0] exp_err[10] = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'hD, 4'hC, 4'h3};

  task automatic put(input logic crs, input logic [1:0] d, input logic er, input int n);
    bus.phy2rmii_crs_dv = crs;
    bus.phy2rmii_rxd    = d;
    bus.phy2rmii_rx_er  = er;
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic sync();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic send_preamble(input int hold);
    for (int i = 0; i < 15; i++) put(1'b1, 2'b01, 1'b0, hold);
    put(1'b1, 2'b11, 1'b0, hold);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input logic [3:0] er_mask);
    for (int i = 0; i < 4; i++) put(1'b1, b[2*i +: 2], er_mask[i], hold);
  endtask

  task automatic send_end(input int hold);
    put(1'b0, 2'b00, 1'b0, hold);
    put(1'b0, 2'b00, 1'b0, hold);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.speed_100 = 1'b1;
    put(1'b1, 2'b01, 1'b1, 3);
    @(negedge sys_clk);
    total_cnt++;
    if (bus.mii_rxd !== 4'h0) $display("FAIL reset_rxd got=%0h exp=0", bus.mii_rxd);
    else pass_cnt++;
    total_cnt++;
    if (bus.mii_rx_en !== 1'b0) $display("FAIL reset_en got=%0b exp=0", bus.mii_rx_en);
    else pass_cnt++;
    total_cnt++;
    if (bus.mii_rx_dv !== 1'b0) $display("FAIL reset_dv got=%0b exp=0", bus.mii_rx_dv);
    else pass_cnt++;
    total_cnt++;
    if (bus.mii_rx_er !== 1'b0) $display("FAIL reset_er got=%0b exp=0", bus.mii_rx_er);
    else pass_cnt++;
    total_cnt++;
    if (bus.mii_crs !== 1'b0) $display("FAIL reset_crs got=%0b exp=0", bus.mii_crs);
    else pass_cnt++;
    put(1'b0, 2'b00, 1'b0, 1);
    resetn = 1'b1;
    put(1'b0, 2'b00, 1'b0, 4);
  endtask

  task automatic test_frame_100();
    int base, fb, cb, nb, t_lat;
    sync();
    base = nib_q.size(); fb = dv_falls; cb = consec_viol; nb = nodv_viol;
    put(1'b1, 2'b01, 1'b0, 1);
    put(1'b1, 2'b01, 1'b0, 1);
    t_lat = cyc;
    for (int i = 0; i < 13; i++) put(1'b1, 2'b01, 1'b0, 1);
    put(1'b1, 2'b11, 1'b0, 1);
    send_byte(8'hA5, 1, 4'b0000);
    send_end(1);
    put(1'b0, 2'b00, 1'b0, 6);
    total_cnt++;
    if (nib_q.size() - base != 10) $display("FAIL f100_count got=%0d exp=10", nib_q.size() - base);
    else pass_cnt++;
    if (nib_q.size() - base == 10) begin
      for (int i = 0; i < 10; i++) begin
        total_cnt++;
        if (nib_q[base+i] !== exp_std[i] || ner_q[base+i] !== 1'b0)
          $display("FAIL f100_nib%0d got=%0h/%0b exp=%0h/0", i, nib_q[base+i], ner_q[base+i],
                   exp_std[i]);
        else pass_cnt++;
      end
      total_cnt++;
      if (t_q[base] !== t_lat) $display("FAIL f100_latency got=%0d exp=%0d", t_q[base], t_lat);
      else pass_cnt++;
      for (int i = 1; i < 10; i++) begin
        total_cnt++;
        if (t_q[base+i] - t_q[base+i-1] != 2)
          $display("FAIL f100_spacing%0d got=%0d exp=2", i, t_q[base+i] - t_q[base+i-1]);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (dv_falls - fb != 1) $display("FAIL f100_dv_cont got=%0d falls exp=1", dv_falls - fb);
    else pass_cnt++;
    total_cnt++;
    if (consec_viol != cb || nodv_viol != nb)
      $display("FAIL f100_en_rules got=%0d/%0d exp=0/0", consec_viol - cb, nodv_viol - nb);
    else pass_cnt++;
  endtask

  task automatic test_toggle_end();
    int base;
    sync();
    base = nib_q.size();
    send_preamble(1);
    send_byte(8'hA5, 1, 4'b0000);
    put(1'b0, 2'b00, 1'b0, 1);
    put(1'b1, 2'b11, 1'b0, 1);
    put(1'b0, 2'b11, 1'b0, 1);
    put(1'b1, 2'b00, 1'b0, 1);
    put(1'b1, 2'b10, 1'b0, 1);
    put(1'b0, 2'b00, 1'b0, 1);
    @(negedge sys_clk);
    total_cnt++;
    if (bus.mii_rx_dv !== 1'b1 || bus.mii_crs !== 1'b0)
      $display("FAIL tog_first_low got=dv%0b/crs%0b exp=dv1/crs0", bus.mii_rx_dv, bus.mii_crs);
    else pass_cnt++;
    put(1'b0, 2'b00, 1'b0, 1);
    @(negedge sys_clk);
    total_cnt++;
    if (bus.mii_rx_dv !== 1'b0) $display("FAIL tog_dv_fall got=%0b exp=0", bus.mii_rx_dv);
    else pass_cnt++;
    put(1'b0, 2'b00, 1'b0, 5);
    total_cnt++;
    if (nib_q.size() - base != 12) $display("FAIL tog_count got=%0d exp=12", nib_q.size() - base);
    else pass_cnt++;
    if (nib_q.size() - base == 12) begin
      for (int i = 8; i < 12; i++) begin
        total_cnt++;
        if (nib_q[base+i] !== exp_tog[i])
          $display("FAIL tog_nib%0d got=%0h exp=%0h", i, nib_q[base+i], exp_tog[i]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_frame_10m();
    int base;
    sync();
    bus.speed_100 = 1'b0;
    put(1'b0, 2'b00, 1'b0, 25);
    base = nib_q.size();
    for (int i = 0; i < 15; i++) begin
      if (i == 4) bus.speed_100 = 1'b1;
      put(1'b1, 2'b01, 1'b0, 10);
    end
    put(1'b1, 2'b11, 1'b0, 10);
    send_byte(8'hA5, 10, 4'b0000);
    send_end(10);
    put(1'b0, 2'b00, 1'b0, 20);
    total_cnt++;
    if (nib_q.size() - base != 10) $display("FAIL f10_count got=%0d exp=10", nib_q.size() - base);
    else pass_cnt++;
    if (nib_q.size() - base == 10) begin
      for (int i = 0; i < 10; i++) begin
        total_cnt++;
        if (nib_q[base+i] !== exp_std[i])
          $display("FAIL f10_nib%0d got=%0h exp=%0h", i, nib_q[base+i], exp_std[i]);
        else pass_cnt++;
      end
      for (int i = 1; i < 10; i++) begin
        total_cnt++;
        if (t_q[base+i] - t_q[base+i-1] != 20)
          $display("FAIL f10_spacing%0d got=%0d exp=20", i, t_q[base+i] - t_q[base+i-1]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_rx_error();
    int base;
    sync();
    base = nib_q.size();
    send_preamble(1);
    send_byte(8'h3C, 1, 4'b0100);
    send_end(1);
    put(1'b0, 2'b00, 1'b0, 4);
    total_cnt++;
    if (nib_q.size() - base != 10) $display("FAIL err_count got=%0d exp=10", nib_q.size() - base);
    else pass_cnt++;
    if (nib_q.size() - base == 10) begin
      for (int i = 0; i < 10; i++) begin
        total_cnt++;
        if (nib_q[base+i] !== exp_err[i] || ner_q[base+i] !== (i == 9))
          $display("FAIL err_nib%0d got=%0h/%0b exp=%0h/%0b", i, nib_q[base+i], ner_q[base+i],
                   exp_err[i], (i == 9));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_false_carrier_reset();
    int base;
    sync();
    base = nib_q.size();
    for (int i = 0; i < 6; i++) put(1'b1, 2'b10, 1'b0, 1);
    put(1'b0, 2'b00, 1'b0, 3);
    @(negedge sys_clk);
    total_cnt++;
    if (nib_q.size() != base || bus.mii_rx_dv !== 1'b0)
      $display("FAIL false_carrier got=%0d nibbles dv%0b exp=0 dv0", nib_q.size() - base,
               bus.mii_rx_dv);
    else pass_cnt++;
    send_preamble(1);
    put(1'b1, 2'b01, 1'b0, 1);
    put(1'b1, 2'b10, 1'b0, 1);
    resetn = 1'b0;
    put(1'b1, 2'b01, 1'b0, 1);
    @(negedge sys_clk);
    total_cnt++;
    if ({bus.mii_rxd, bus.mii_rx_en, bus.mii_rx_dv, bus.mii_rx_er, bus.mii_crs} !== 8'h00)
      $display("FAIL midreset_outs got=%0h exp=0",
               {bus.mii_rxd, bus.mii_rx_en, bus.mii_rx_dv, bus.mii_rx_er, bus.mii_crs});
    else pass_cnt++;
    base = nib_q.size();
    put(1'b1, 2'b10, 1'b0, 1);
    resetn = 1'b1;
    put(1'b1, 2'b11, 1'b0, 1);
    put(1'b1, 2'b10, 1'b0, 1);
    put(1'b1, 2'b11, 1'b0, 1);
    put(1'b1, 2'b00, 1'b0, 1);
    put(1'b0, 2'b00, 1'b0, 3);
    total_cnt++;
    if (nib_q.size() != base) $display("FAIL post_reset_quiet got=%0d exp=0", nib_q.size() - base);
    else pass_cnt++;
    send_preamble(1);
    send_byte(8'hA5, 1, 4'b0000);
    send_end(1);
    put(1'b0, 2'b00, 1'b0, 4);
    total_cnt++;
    if (nib_q.size() - base != 10) $display("FAIL refr_count got=%0d exp=10", nib_q.size() - base);
    else pass_cnt++;
    if (nib_q.size() - base == 10) begin
      for (int i = 0; i < 10; i++) begin
        total_cnt++;
        if (nib_q[base+i] !== exp_std[i])
          $display("FAIL refr_nib%0d got=%0h exp=%0h", i, nib_q[base+i], exp_std[i]);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    bus.speed_100       = 1'b1;
    bus.phy2rmii_crs_dv = 1'b0;
    bus.phy2rmii_rx_er  = 1'b0;
    bus.phy2rmii_rxd    = 2'b00;
    test_reset();
    test_frame_100();
    test_toggle_end();
    test_frame_10m();
    test_rx_error();
    test_false_carrier_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
